axi_lite_slave: RTL and testbench

AXI4-Lite slave that terminates the transactions issued by `axi_lite_master` and serves them from a small memory-mapped register file. It sits directly downstream of the master on the same AXI4-Lite link. Read and write paths run independently, with one outstanding transaction per direction. Writes honour byte strobes, and out-of-range addresses return SLVERR.

---
 rtl/axi_lite_pkg.sv | 35 +++
 rtl/axi_lite_regfile.sv | 45 ++++
 rtl/axi_lite_slave.sv | 199 +++++++++++++++++++
 tb/tb_axi_lite_slave.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_pkg : shared AXI4-Lite types, FSM encodings and address decode
// Revision     : 1.0
// ---------------------------------------------------------------------------
package axi_lite_pkg;

  typedef logic [11:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam logic [1:0] W_IDLE      = 2'd0;
  localparam logic [1:0] W_HAVE_ADDR = 2'd1;
  localparam logic [1:0] W_HAVE_DATA = 2'd2;
  localparam logic [1:0] W_RESP      = 2'd3;

  localparam logic R_IDLE = 1'b0;
  localparam logic R_DATA = 1'b1;

  // The explicit lower-bound test keeps addresses below BASE from wrapping in.
  function automatic logic addr_in_range(input addr_t addr, input addr_t base,
                                         input int unsigned num_regs);
    logic [12:0] off;
    if (addr < base) return 1'b0;
    off = {1'b0, addr - base};
    return (off < 13'(num_regs * 4));
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_lite_regfile.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_regfile : NUM_REGS x 32 storage, byte-enable write, async read
// Revision         : 1.0
// ---------------------------------------------------------------------------
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 16
) (
  input  logic                        aclk,
  input  logic                        areset_n,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] waddr,
  input  data_t                       wdata,
  input  strb_t                       wbe,
  input  logic [$clog2(NUM_REGS)-1:0] raddr,
  output data_t                       rdata
);

  data_t mem_q [NUM_REGS];
  data_t mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe[b]) mem_d[waddr][8*b +: 8] = wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Reads the registered value, so a same-edge write is not yet visible.
  assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/axi_lite_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_lite_slave : AXI4-Lite slave serving a memory-mapped register file
// Revision       : 1.0
// ---------------------------------------------------------------------------
module axi_lite_slave
  import axi_lite_pkg::*;
#(
  parameter int    NUM_REGS  = 16,
  parameter addr_t BASE_ADDR = 12'h000,
  parameter bit    USE_WSTRB = 1'b1
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic [11:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  input  logic [11:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [1:0] wstate_q, wstate_d;
  logic       rstate_q, rstate_d;
  addr_t      awaddr_q, awaddr_d;
  data_t      wdata_q,  wdata_d;
  strb_t      wstrb_q,  wstrb_d;
  resp_t      bresp_q,  bresp_d;
  data_t      rdata_q,  rdata_d;
  resp_t      rresp_q,  rresp_d;

  logic       aw_hs, w_hs, ar_hs, commit;
  addr_t      commit_addr, wr_off, rd_off;
  data_t      commit_data, rf_rdata;
  strb_t      commit_strb, rf_be;
  logic       wr_in_range, rd_in_range, rf_we;
  logic [IDX_W-1:0] wr_idx, rd_idx;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;

  // ---------------- write FSM ----------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) wstate_q <= W_IDLE;
    else           wstate_q <= wstate_d;
  end

  always_comb begin
    wstate_d = wstate_q;
    commit   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wstate_d = W_RESP;
          commit   = 1'b1;
        end else if (aw_hs) begin
          wstate_d = W_HAVE_ADDR;
        end else if (w_hs) begin
          wstate_d = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: if (w_hs) begin
        wstate_d = W_RESP;
        commit   = 1'b1;
      end
      W_HAVE_DATA: if (aw_hs) begin
        wstate_d = W_RESP;
        commit   = 1'b1;
      end
      W_RESP:  if (bready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    if (areset_n) begin
      awready = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_DATA);
      wready  = (wstate_q == W_IDLE) || (wstate_q == W_HAVE_ADDR);
      bvalid  = (wstate_q == W_RESP);
    end
  end

  // The half that arrives on the committing edge bypasses its holding register.
  assign commit_addr = (wstate_q == W_HAVE_ADDR) ? awaddr_q : awaddr;
  assign commit_data = (wstate_q == W_HAVE_DATA) ? wdata_q  : wdata;
  assign commit_strb = (wstate_q == W_HAVE_DATA) ? wstrb_q  : wstrb;

  assign wr_in_range = addr_in_range(commit_addr, BASE_ADDR, NUM_REGS);
  assign wr_off      = commit_addr - BASE_ADDR;
  assign wr_idx      = IDX_W'(wr_off >> 2);
  assign rf_we       = commit & wr_in_range;
  assign rf_be       = USE_WSTRB ? commit_strb : 4'hF;

  always_comb begin
    awaddr_d = aw_hs ? awaddr : awaddr_q;
    wdata_d  = w_hs  ? wdata  : wdata_q;
    wstrb_d  = w_hs  ? wstrb  : wstrb_q;
    bresp_d  = bresp_q;
    if (commit) bresp_d = wr_in_range ? OKAY : SLVERR;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= OKAY;
    end else begin
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
    end
  end

  assign bresp = bresp_q;

  // ---------------- read FSM ----------------
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) rstate_q <= R_IDLE;
    else           rstate_q <= rstate_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    case (rstate_q)
      R_IDLE:  if (ar_hs)  rstate_d = R_DATA;
      R_DATA:  if (rready) rstate_d = R_IDLE;
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    arready = 1'b0;
    rvalid  = 1'b0;
    if (areset_n) begin
      arready = (rstate_q == R_IDLE);
      rvalid  = (rstate_q == R_DATA);
    end
  end

  assign rd_in_range = addr_in_range(araddr, BASE_ADDR, NUM_REGS);
  assign rd_off      = araddr - BASE_ADDR;
  assign rd_idx      = IDX_W'(rd_off >> 2);

  always_comb begin
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    if (ar_hs) begin
      rdata_d = rd_in_range ? rf_rdata : '0;
      rresp_d = rd_in_range ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      rdata_q <= '0;
      rresp_q <= OKAY;
    end else begin
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
    end
  end

  assign rdata = rdata_q;
  assign rresp = rresp_q;

  axi_lite_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .aclk     (aclk),
    .areset_n (areset_n),
    .we       (rf_we),
    .waddr    (wr_idx),
    .wdata    (commit_data),
    .wbe      (rf_be),
    .raddr    (rd_idx),
    .rdata    (rf_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axi_lite_slave : directed bench, strobed instance plus USE_WSTRB=0 twin
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_axi_lite_slave;
  import axi_lite_pkg::*;

  localparam int TMO = 20;

  logic        aclk = 1'b0;
  logic        areset_n = 1'b0;
  logic [11:0] awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;

  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        n_awready, n_wready, n_bvalid, n_arready, n_rvalid;
  logic [1:0]  n_bresp, n_rresp;
  logic [31:0] n_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] model [16];

  always #5 aclk = ~aclk;

  axi_lite_slave #(.NUM_REGS(16), .BASE_ADDR(12'h000), .USE_WSTRB(1'b1)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  axi_lite_slave #(.NUM_REGS(16), .BASE_ADDR(12'h000), .USE_WSTRB(1'b0)) dut_nw (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(n_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(n_wready),
    .bresp(n_bresp), .bvalid(n_bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(n_arready),
    .rdata(n_rdata), .rresp(n_rresp), .rvalid(n_rvalid), .rready(rready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model of the strobed instance; 16 regs at base 0.
  task automatic model_wr(input addr_t a, input data_t d, input strb_t s);
    if (a < 12'h040) begin
      for (int b = 0; b < 4; b++)
        if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  // Both tasks are entered and left on a falling edge.
  task automatic do_write(input addr_t a, input data_t d, input strb_t s,
                          output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!(awready && wready) && n < TMO) begin @(negedge aclk); n++; end
    chk("aw_w_wait", 32'(n < TMO), 32'd1);
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("bvalid_latency", 32'(bvalid), 32'd1);
    resp = bresp;
    model_wr(a, d, s);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic do_read(input addr_t a, output data_t d, output logic [1:0] r,
                         output data_t nd);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < TMO) begin @(negedge aclk); n++; end
    chk("ar_wait", 32'(n < TMO), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rvalid_latency", 32'(rvalid), 32'd1);
    d = rdata; r = rresp; nd = n_rdata;
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    addr_t       addr;
    data_t       data;
    strb_t       strb;
    data_t       exp_data;
    data_t       exp_n;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    data_t d, nd;
    logic [1:0] r;

    for (int i = 0; i < 16; i++) model[i] = '0;

    vecs[0]  = '{1'b1, 12'h008, 32'hDEADBEEF, 4'hF, 32'h0,        32'h0,        2'b00};
    vecs[1]  = '{1'b0, 12'h008, 32'h0,        4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[2]  = '{1'b1, 12'h00C, 32'h12345678, 4'h5, 32'h0,        32'h0,        2'b00};
    vecs[3]  = '{1'b0, 12'h00C, 32'h0,        4'h0, 32'h00340078, 32'h12345678, 2'b00};
    vecs[4]  = '{1'b1, 12'h03C, 32'hA5A5A5A5, 4'hF, 32'h0,        32'h0,        2'b00};
    vecs[5]  = '{1'b0, 12'h03F, 32'h0,        4'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};
    vecs[6]  = '{1'b1, 12'h040, 32'hFFFFFFFF, 4'hF, 32'h0,        32'h0,        2'b10};
    vecs[7]  = '{1'b0, 12'h040, 32'h0,        4'h0, 32'h0,        32'h0,        2'b10};
    vecs[8]  = '{1'b0, 12'h000, 32'h0,        4'h0, 32'h0,        32'h0,        2'b00};
    vecs[9]  = '{1'b1, 12'h7FC, 32'h11111111, 4'hF, 32'h0,        32'h0,        2'b10};
    vecs[10] = '{1'b0, 12'hFFC, 32'h0,        4'h0, 32'h0,        32'h0,        2'b10};
    vecs[11] = '{1'b0, 12'h03C, 32'h0,        4'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00};

    // Power-on reset
    #12;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    chk("rst_rresp",   32'(rresp),   32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    chk("idle_awready", 32'(awready), 32'd1);
    chk("idle_wready",  32'(wready),  32'd1);
    chk("idle_arready", 32'(arready), 32'd1);
    @(negedge aclk);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r);
        chk($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, d, r, nd);
        chk($sformatf("v%0d_rdata", i),   d,       vecs[i].exp_data);
        chk($sformatf("v%0d_rresp", i),   32'(r),  32'(vecs[i].exp_resp));
        chk($sformatf("v%0d_nw_rdata", i), nd,     vecs[i].exp_n);
      end
    end

    // Strobe 0: ignored bytes on strobed instance, full write on the twin
    do_write(12'h008, 32'h000000AA, 4'h0, r);
    chk("strb0_bresp", 32'(r), 32'd0);
    do_read(12'h008, d, r, nd);
    chk("strb0_rdata",    d,  32'hDEADBEEF);
    chk("strb0_nw_rdata", nd, 32'h000000AA);

    // W three cycles ahead of AW
    wdata = 32'h000000AA; wstrb = 4'h1; wvalid = 1'b1;
    @(negedge aclk);
    wvalid = 1'b0;
    chk("wfirst_wready",  32'(wready),  32'd0);
    chk("wfirst_awready", 32'(awready), 32'd1);
    chk("wfirst_bvalid",  32'(bvalid),  32'd0);
    @(negedge aclk);
    @(negedge aclk);
    awaddr = 12'h008; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("wfirst_bvalid_lat", 32'(bvalid), 32'd1);
    chk("wfirst_bresp",      32'(bresp),  32'd0);
    model_wr(12'h008, 32'h000000AA, 4'h1);
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    do_read(12'h008, d, r, nd);
    chk("wfirst_rdata",    d,  32'hDEADBEAA);
    chk("wfirst_nw_rdata", nd, 32'h000000AA);

    // Write response backpressure
    awaddr = 12'h010; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    model_wr(12'h010, 32'hCAFEF00D, 4'hF);
    for (int k = 0; k < 5; k++) begin
      chk("bp_bvalid",  32'(bvalid),  32'd1);
      chk("bp_bresp",   32'(bresp),   32'd0);
      chk("bp_awready", 32'(awready), 32'd0);
      chk("bp_wready",  32'(wready),  32'd0);
      @(negedge aclk);
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk("bp_bvalid_drop", 32'(bvalid), 32'd0);

    // Read response backpressure with a second AR waiting
    araddr = 12'h008; arvalid = 1'b1;
    @(negedge aclk);
    araddr = 12'h00C;
    for (int k = 0; k < 5; k++) begin
      chk("rbp_rvalid",  32'(rvalid),  32'd1);
      chk("rbp_rdata",   rdata,        32'hDEADBEAA);
      chk("rbp_rresp",   32'(rresp),   32'd0);
      chk("rbp_arready", 32'(arready), 32'd0);
      @(negedge aclk);
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    chk("rbp_rvalid_drop", 32'(rvalid),  32'd0);
    chk("rbp_arready_up",  32'(arready), 32'd1);
    @(negedge aclk);
    arvalid = 1'b0;
    chk("rbp_second_rvalid", 32'(rvalid), 32'd1);
    chk("rbp_second_rdata",  rdata,       32'h00340078);
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;

    // Same-register read and write commit on one edge
    do_write(12'h004, 32'h00000001, 4'hF, r);
    araddr = 12'h004; arvalid = 1'b1;
    awaddr = 12'h004; wdata = 32'h00000002; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge aclk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    model_wr(12'h004, 32'h00000002, 4'hF);
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_rdata",  rdata,       32'h00000001);
    rready = 1'b1; bready = 1'b1;
    @(negedge aclk);
    rready = 1'b0; bready = 1'b0;
    do_read(12'h004, d, r, nd);
    chk("coll_next_rdata", d, 32'h00000002);

    // Full sweep against the model
    for (int i = 0; i < 16; i++) begin
      do_read(addr_t'(i * 4), d, r, nd);
      chk($sformatf("sweep_r%0d", i),      d,      model[i]);
      chk($sformatf("sweep_r%0d_resp", i), 32'(r), 32'd0);
    end

    // Reset while AW is held and W is still pending
    awaddr = 12'h000; awvalid = 1'b1;
    @(negedge aclk);
    awvalid = 1'b0;
    chk("mid_awready", 32'(awready), 32'd0);
    chk("mid_wready",  32'(wready),  32'd1);
    wdata = 32'h55555555; wstrb = 4'hF;
    #2 areset_n = 1'b0;
    #1;
    chk("mrst_awready", 32'(awready), 32'd0);
    chk("mrst_wready",  32'(wready),  32'd0);
    chk("mrst_arready", 32'(arready), 32'd0);
    chk("mrst_bvalid",  32'(bvalid),  32'd0);
    chk("mrst_rvalid",  32'(rvalid),  32'd0);
    chk("mrst_rdata",   rdata,        32'd0);
    @(negedge aclk);
    @(negedge aclk);
    areset_n = 1'b1;
    #1;
    chk("mrst_idle_awready", 32'(awready), 32'd1);
    chk("mrst_idle_wready",  32'(wready),  32'd1);
    @(negedge aclk);
    do_read(12'h000, d, r, nd);
    chk("mrst_r0_rdata", d,      32'd0);
    chk("mrst_r0_rresp", 32'(r), 32'd0);
    do_read(12'h008, d, r, nd);
    chk("mrst_r2_cleared", d, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
